// File: rtl/isr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isr_pkg
//  Description : Shared definitions for the in-service register block:
//                OCW2 command bit positions, the last-serviced reset value
//                and a 3-bit level to one-hot byte converter.
//  Revision    : 1.0  initial release
// ============================================================================
package isr_pkg;

    // Bit positions inside the OCW2 {R, SL, EOI} command field
    localparam int OCW2_EOI = 0;
    localparam int OCW2_SL  = 1;
    localparam int OCW2_R   = 2;

    // IR7 marked as last serviced so IR0 starts with the highest priority
    localparam logic [7:0] LAST_SERVICED_RESET = 8'b1000_0000;

    function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
        return 8'b0000_0001 << level;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isr_if.sv
`default_nettype none
// ============================================================================
//  Module      : isr_if
//  Description : Signal bundle between the control logic / priority resolver
//                (master) and the in-service register block (slave).
//                  mode                       AEOI (1) or normal EOI (0)
//                  modes_of_end_of_interrupt  OCW2 {R, SL, EOI}
//                  interrupt_special_mask     special-mask level mask
//                  highest_priority_interrupt one-hot granted level
//                  acknowledge                INTA level
//                  end_of_interrupt           one-hot level for non-specific EOI
//                  specific_level_clear       level for specific EOI (8-15 invalid)
//                  in_service_register        registered in-service bits
//                  last_serviced              registered one-hot last level
//  Revision    : 1.0  initial release
// ============================================================================
interface isr_if;

    logic       mode;
    logic [2:0] modes_of_end_of_interrupt;
    logic [7:0] interrupt_special_mask;
    logic [7:0] highest_priority_interrupt;
    logic       acknowledge;
    logic [7:0] end_of_interrupt;
    logic [3:0] specific_level_clear;
    logic [7:0] in_service_register;
    logic [7:0] last_serviced;

    modport master (
        output mode,
        output modes_of_end_of_interrupt,
        output interrupt_special_mask,
        output highest_priority_interrupt,
        output acknowledge,
        output end_of_interrupt,
        output specific_level_clear,
        input  in_service_register,
        input  last_serviced
    );

    modport slave (
        input  mode,
        input  modes_of_end_of_interrupt,
        input  interrupt_special_mask,
        input  highest_priority_interrupt,
        input  acknowledge,
        input  end_of_interrupt,
        input  specific_level_clear,
        output in_service_register,
        output last_serviced
    );

endinterface
`default_nettype wire

// File: rtl/isr_ack_edge.sv
`default_nettype none
// ============================================================================
//  Module      : isr_ack_edge
//  Description : Registers the acknowledge level and produces single-cycle
//                rising / falling edge strobes from it.
//                  clk, reset        clock, synchronous active-high reset
//                  i_acknowledge     INTA level
//                  o_ack_rise        acknowledge high, was low last cycle
//                  o_ack_fall        acknowledge low, was high last cycle
//  Revision    : 1.0  initial release
// ============================================================================
module isr_ack_edge (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_acknowledge,
    output logic      o_ack_rise,
    output logic      o_ack_fall
);

    logic r_ack_q;

    // Cleared by reset, so an acknowledge still held after reset is seen
    // as a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_q <= 1'b0;
        end else begin
            r_ack_q <= i_acknowledge;
        end
    end

    assign o_ack_rise = i_acknowledge  & ~r_ack_q;
    assign o_ack_fall = ~i_acknowledge &  r_ack_q;

endmodule
`default_nettype wire

// File: rtl/isr.sv
`default_nettype none
// ============================================================================
//  Module      : isr
//  Description : In-service register of an 8259A-compatible interrupt
//                controller. Records the granted level on each acknowledge,
//                clears levels on automatic, non-specific or specific EOI and
//                tracks the last serviced level used for priority rotation.
//                  clk    system clock
//                  reset  synchronous active-high reset
//                  bus    isr_if slave modport (inputs and registered outputs)
//                Build option: ISR_SPECIAL_MASK_EN -- when defined,
//                non-specific EOI skips levels set in interrupt_special_mask.
//  Revision    : 1.0  initial release
// ============================================================================
module isr
    import isr_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    isr_if.slave      bus
);

    logic       w_ack_rise;
    logic       w_ack_fall;
    logic       w_cmd_live;
    logic [7:0] w_set;
    logic [7:0] w_aeoi_clr;
    logic [7:0] w_eoi_mask;
    logic [7:0] w_eoi_clr;
    logic [7:0] w_isr_next;
    logic [7:0] w_rot_cleared;

    logic [7:0] r_isr;
    logic [7:0] r_last;
    logic [7:0] r_aeoi_level;

    isr_ack_edge u_ack_edge (
        .clk           (clk),
        .reset         (reset),
        .i_acknowledge (bus.acknowledge),
        .o_ack_rise    (w_ack_rise),
        .o_ack_fall    (w_ack_fall)
    );

    always_comb begin
        w_cmd_live = bus.modes_of_end_of_interrupt[OCW2_EOI];
        w_set      = w_ack_rise ? bus.highest_priority_interrupt : 8'h00;
        // AEOI retires exactly the level latched at the matching rising edge
        w_aeoi_clr = (bus.mode && w_ack_fall) ? r_aeoi_level : 8'h00;

`ifdef ISR_SPECIAL_MASK_EN
        w_eoi_mask = ~bus.interrupt_special_mask;
`else
        w_eoi_mask = 8'hFF;
`endif

        w_eoi_clr = 8'h00;
        if (w_cmd_live) begin
            if (!bus.modes_of_end_of_interrupt[OCW2_SL]) begin
                w_eoi_clr = bus.end_of_interrupt & w_eoi_mask;
            end else if (!bus.specific_level_clear[3]) begin
                w_eoi_clr = level_to_onehot(bus.specific_level_clear[2:0]);
            end
        end

        // Set is applied after clear so a same-bit collision keeps the bit
        w_isr_next = (r_isr & ~(w_aeoi_clr | w_eoi_clr)) | w_set;

        // Only a bit that was actually in service and not re-set this cycle
        // counts as cleared for rotation.
        w_rot_cleared = 8'h00;
        if (w_cmd_live && bus.modes_of_end_of_interrupt[OCW2_R]) begin
            w_rot_cleared = w_eoi_clr & r_isr & ~w_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_isr        <= 8'h00;
            r_last       <= LAST_SERVICED_RESET;
            r_aeoi_level <= 8'h00;
        end else begin
            r_isr <= w_isr_next;
            if (w_ack_rise) begin
                r_aeoi_level <= bus.highest_priority_interrupt;
            end
            // Acknowledge update takes precedence over rotate-on-EOI
            if (w_ack_rise && (|bus.highest_priority_interrupt)) begin
                r_last <= bus.highest_priority_interrupt;
            end else if (|w_rot_cleared) begin
                r_last <= w_rot_cleared;
            end
        end
    end

    assign bus.in_service_register = r_isr;
    assign bus.last_serviced       = r_last;

endmodule
`default_nettype wire

// File: tb/tb_isr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isr
//  Description : Self-checking testbench for isr. Directed scenarios plus a
//                randomized run against a level-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_isr;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    isr_if bus ();

    isr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef ISR_SPECIAL_MASK_EN
    localparam bit SMEN = 1'b1;
`else
    localparam bit SMEN = 1'b0;
`endif

    // Behavioural model: per-level in-service flags, last level as a number
    bit m_isr [8];
    int m_last;
    bit m_ack_prev;
    int m_aeoi;

    function automatic logic [7:0] m_isr_byte();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = m_isr[i];
        return b;
    endfunction

    function automatic logic [7:0] m_last_byte();
        logic [7:0] b;
        b = 8'h00;
        b[m_last] = 1'b1;
        return b;
    endfunction

    // Advance model using inputs presented this cycle, then clock the DUT
    task automatic cycle();
        bit rise, fall;
        int granted, cleared, slc;
        bit nxt [8];
        if (reset) begin
            for (int i = 0; i < 8; i++) m_isr[i] = 1'b0;
            m_last = 7; m_ack_prev = 1'b0; m_aeoi = -1;
        end else begin
            rise = bus.acknowledge && !m_ack_prev;
            fall = !bus.acknowledge && m_ack_prev;
            granted = -1;
            for (int i = 0; i < 8; i++) if (bus.highest_priority_interrupt[i]) granted = i;
            for (int i = 0; i < 8; i++) nxt[i] = m_isr[i];
            cleared = -1;
            if (fall && bus.mode && m_aeoi >= 0) nxt[m_aeoi] = 1'b0;
            if (bus.modes_of_end_of_interrupt[0]) begin
                if (!bus.modes_of_end_of_interrupt[1]) begin
                    for (int i = 0; i < 8; i++) begin
                        if (bus.end_of_interrupt[i] && !(SMEN && bus.interrupt_special_mask[i])) begin
                            if (m_isr[i]) cleared = i;
                            nxt[i] = 1'b0;
                        end
                    end
                end else begin
                    slc = int'(bus.specific_level_clear);
                    if (slc < 8) begin
                        if (m_isr[slc]) cleared = slc;
                        nxt[slc] = 1'b0;
                    end
                end
            end
            if (rise && granted >= 0) begin
                nxt[granted] = 1'b1;
                if (cleared == granted) cleared = -1;
            end
            for (int i = 0; i < 8; i++) m_isr[i] = nxt[i];
            if (rise && granted >= 0) m_last = granted;
            else if (bus.modes_of_end_of_interrupt[2] && bus.modes_of_end_of_interrupt[0] && cleared >= 0)
                m_last = cleared;
            if (rise) m_aeoi = granted;
            m_ack_prev = bus.acknowledge;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mode = 1'b0;
        bus.modes_of_end_of_interrupt = 3'b000;
        bus.interrupt_special_mask = 8'h00;
        bus.highest_priority_interrupt = 8'h00;
        bus.acknowledge = 1'b0;
        bus.end_of_interrupt = 8'h00;
        bus.specific_level_clear = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_ack(input logic [7:0] hpi);
        bus.acknowledge = 1'b1;
        bus.highest_priority_interrupt = hpi;
        cycle();
        bus.acknowledge = 1'b0;
        bus.highest_priority_interrupt = 8'h00;
        cycle();
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [7:0] eoi, input logic [3:0] slc);
        bus.modes_of_end_of_interrupt = cmd;
        bus.end_of_interrupt = eoi;
        bus.specific_level_clear = slc;
        cycle();
        bus.modes_of_end_of_interrupt = 3'b000;
        bus.end_of_interrupt = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.in_service_register !== 8'h00) begin
            bad++; $display("FAIL reset_isr got=%h want=00", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h80) begin
            bad++; $display("FAIL reset_last got=%h want=80", bus.last_serviced);
        end
    endtask

    task automatic test_aeoi();
        do_reset();
        bus.mode = 1'b1;
        bus.acknowledge = 1'b1;
        bus.highest_priority_interrupt = 8'b0010_0000;
        cycle();
        total++;
        if (bus.in_service_register !== 8'h20) begin
            bad++; $display("FAIL aeoi_set_isr got=%h want=20", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h20) begin
            bad++; $display("FAIL aeoi_set_last got=%h want=20", bus.last_serviced);
        end
        bus.acknowledge = 1'b0;
        bus.highest_priority_interrupt = 8'h00;
        cycle();
        total++;
        if (bus.in_service_register !== 8'h00) begin
            bad++; $display("FAIL aeoi_clr_isr got=%h want=00", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h20) begin
            bad++; $display("FAIL aeoi_clr_last got=%h want=20", bus.last_serviced);
        end
    endtask

    task automatic test_normal_eoi();
        do_reset();
        do_ack(8'b0000_1000);
        do_ack(8'b0000_0010);
        total++;
        if (bus.in_service_register !== 8'h0A) begin
            bad++; $display("FAIL normal_two_acks got=%h want=0a", bus.in_service_register);
        end
        send_cmd(3'b001, 8'b0000_0010, 4'h0);
        total++;
        if (bus.in_service_register !== 8'h08) begin
            bad++; $display("FAIL nonspecific_eoi got=%h want=08", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h02) begin
            bad++; $display("FAIL nonrotate_last got=%h want=02", bus.last_serviced);
        end
    endtask

    task automatic test_specific_rotate();
        send_cmd(3'b111, 8'h00, 4'd3);
        total++;
        if (bus.in_service_register !== 8'h00) begin
            bad++; $display("FAIL spec_rot_isr got=%h want=00", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h08) begin
            bad++; $display("FAIL spec_rot_last got=%h want=08", bus.last_serviced);
        end
        do_ack(8'b0010_0000);
        send_cmd(3'b111, 8'h00, 4'd13);
        total++;
        if (bus.in_service_register !== 8'h20) begin
            bad++; $display("FAIL spec_invalid_isr got=%h want=20", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h20) begin
            bad++; $display("FAIL spec_invalid_last got=%h want=20", bus.last_serviced);
        end
    endtask

    task automatic test_special_mask();
        logic [7:0] want;
        do_reset();
        do_ack(8'b0000_0100);
        bus.interrupt_special_mask = 8'b0000_0100;
        send_cmd(3'b001, 8'b0000_0100, 4'h0);
        bus.interrupt_special_mask = 8'h00;
        want = SMEN ? 8'h04 : 8'h00;
        total++;
        if (bus.in_service_register !== want) begin
            bad++; $display("FAIL special_mask got=%h want=%h", bus.in_service_register, want);
        end
    endtask

    task automatic test_collision();
        do_reset();
        do_ack(8'b0100_0000);
        // Set IR2 and specific-clear IR2 in the same cycle: set wins
        bus.acknowledge = 1'b1;
        bus.highest_priority_interrupt = 8'b0000_0100;
        send_cmd(3'b011, 8'h00, 4'd2);
        total++;
        if (bus.in_service_register !== 8'h44) begin
            bad++; $display("FAIL collide_same got=%h want=44", bus.in_service_register);
        end
        bus.acknowledge = 1'b0;
        cycle();
        // Set IR1 while rotate-clearing IR6: both apply, ack owns last_serviced
        bus.acknowledge = 1'b1;
        bus.highest_priority_interrupt = 8'b0000_0010;
        send_cmd(3'b111, 8'h00, 4'd6);
        total++;
        if (bus.in_service_register !== 8'h06) begin
            bad++; $display("FAIL collide_diff got=%h want=06", bus.in_service_register);
        end
        total++;
        if (bus.last_serviced !== 8'h02) begin
            bad++; $display("FAIL collide_last got=%h want=02", bus.last_serviced);
        end
        bus.acknowledge = 1'b0;
        bus.highest_priority_interrupt = 8'h00;
        cycle();
    endtask

    task automatic test_reset_during_ack();
        do_reset();
        bus.acknowledge = 1'b1;
        bus.highest_priority_interrupt = 8'b0001_0000;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++;
        if (bus.in_service_register !== 8'h00 || bus.last_serviced !== 8'h80) begin
            bad++; $display("FAIL reset_mid_ack isr=%h last=%h want=00/80",
                            bus.in_service_register, bus.last_serviced);
        end
        cycle();
        total++;
        if (bus.in_service_register !== 8'h10) begin
            bad++; $display("FAIL fresh_rise got=%h want=10", bus.in_service_register);
        end
        bus.acknowledge = 1'b0;
        bus.highest_priority_interrupt = 8'h00;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) bus.mode = 1'($urandom_range(0, 1));
            bus.acknowledge = ($urandom_range(0, 2) == 0);
            bus.highest_priority_interrupt =
                ($urandom_range(0, 4) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) bus.modes_of_end_of_interrupt = 3'($urandom());
            else bus.modes_of_end_of_interrupt = 3'b000;
            bus.end_of_interrupt =
                ($urandom_range(0, 5) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            bus.specific_level_clear = 4'($urandom());
            bus.interrupt_special_mask = 8'($urandom());
            cycle();
            total++;
            if (bus.in_service_register !== m_isr_byte()) begin
                bad++; $display("FAIL rand_isr cyc=%0d got=%h want=%h", n, bus.in_service_register, m_isr_byte());
            end
            total++;
            if (bus.last_serviced !== m_last_byte()) begin
                bad++; $display("FAIL rand_last cyc=%0d got=%h want=%h", n, bus.last_serviced, m_last_byte());
            end
        end
        idle_inputs();
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_aeoi();
        test_normal_eoi();
        test_specific_rotate();
        test_special_mask();
        test_collision();
        test_reset_during_ack();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/isr.md
# isr

In-service register block of the 8259A-compatible interrupt controller. It sits between the priority resolver and the control logic. On each interrupt acknowledge it records the granted IR level in an 8-bit in-service register. It clears levels on automatic, non-specific or specific EOI, and it tracks the last serviced level that priority rotation uses.

## Interface
Parameters: none.
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  EOI mode: 1 = automatic EOI (AEOI), 0 = normal EOI.
- modes_of_end_of_interrupt  in  3  OCW2 command bits {R, SL, EOI}. The command is live in any cycle with bit0 = 1. Upstream pulses it for exactly one clock.
- interrupt_special_mask  in  8  special-mask-mode level mask; 1 = level masked.
- highest_priority_interrupt  in  8  one-hot level granted by the priority resolver.
- acknowledge  in  1  INTA level from control logic; high during acknowledge.
- end_of_interrupt  in  8  one-hot highest-priority in-service level, used by non-specific EOI.
- specific_level_clear  in  4  level for specific EOI. 0–7 select IR0–IR7; 8–15 are invalid and cause no clear.
- in_service_register  out  8  in-service bits, one per IR level; registered.
- last_serviced  out  8  one-hot most recently serviced level; registered.

## Operation
- An internal register ack_q holds acknowledge delayed by one clock.
  - ack_rise = acknowledge & ~ack_q.
  - ack_fall = ~acknowledge & ack_q.
- Set: on ack_rise, in_service_register |= highest_priority_interrupt, and last_serviced <= highest_priority_interrupt. If highest_priority_interrupt is 0, nothing changes.
- AEOI: when mode = 1, on ack_fall, clear the bit latched by the matching ack_rise; that bit is held in an internal register aeoi_level. last_serviced is kept.
- Normal EOI commands apply only when modes_of_end_of_interrupt[0] = 1. They are honoured in either mode.
  - SL = 0 (non-specific): in_service_register &= ~(end_of_interrupt & ~interrupt_special_mask).
  - SL = 1 (specific): clear bit specific_level_clear[2:0], provided specific_level_clear[3] = 0.
  - R = 1: last_serviced <= the one-hot level actually cleared. If no bit was cleared, last_serviced is unchanged.
- Codes with bit0 = 0 (rotate-in-AEOI set/clear, set priority, no-op) do not affect this block.
- Simultaneous events:
  - Set and clear on different bits in one cycle: both apply.
  - Set and clear on the same bit: set wins.
  - Ack update and rotate-EOI update of last_serviced in one cycle: the ack update wins.
- Clearing a bit that is already 0 is harmless.

## Timing
- Reset values: in_service_register = 8'h00, last_serviced = 8'b1000_0000 (IR7, so IR0 has highest priority), ack_q = 0, aeoi_level = 0.
- ISR set is visible one clock after the first cycle acknowledge is sampled high.
- The AEOI clear is visible one clock after the first cycle acknowledge is sampled low.
- An EOI command clears the bit one clock after the cycle in which it is presented.
- Reset during an acknowledge returns all state to reset values. If acknowledge is still high after reset, it produces a fresh ack_rise on the next cycle.
- No combinational path from inputs to outputs.

## Configuration
- ISR_SPECIAL_MASK_EN defined: non-specific EOI skips levels set in interrupt_special_mask, as described above.
- ISR_SPECIAL_MASK_EN undefined: interrupt_special_mask is ignored, and non-specific EOI clears end_of_interrupt directly.

## Structure
- Package isr_pkg holds:
  - OCW2 bit indices (EOI = 0, SL = 1, R = 2).
  - LAST_SERVICED_RESET = 8'b1000_0000.
  - A function that converts a 3-bit level to a one-hot byte.
- One sub-module, isr_ack_edge, registers acknowledge and produces ack_rise and ack_fall.

## Test plan
- Reset only: in_service_register = 00, last_serviced = 80.
- AEOI (reference case): mode = 1, highest_priority_interrupt = 0010_0000, mask = 0, acknowledge high for 1 clock, then low.
  - After the high cycle: ISR = 0010_0000, last_serviced = 0010_0000.
  - One clock after acknowledge falls: ISR = 00, last_serviced = 0010_0000.
- Normal mode: mode = 0, two acks on IR3 then IR1 give ISR = 0000_1010.
  - Non-specific EOI (cmd 001, end_of_interrupt = 0000_0010) then gives ISR = 0000_1000.
- Specific rotate: ISR = 0000_1000, cmd 111, specific_level_clear = 3 gives ISR = 00, last_serviced = 0000_1000.
  - specific_level_clear = 9 with the same command leaves ISR unchanged.
- Special mask: ISR = 0000_0100, mask = 0000_0100, cmd 001, end_of_interrupt = 0000_0100.
  - With ISR_SPECIAL_MASK_EN defined: ISR unchanged.
  - With it undefined: ISR = 00.
- Same-cycle collision: ack_rise on IR2 plus specific EOI on IR2 gives ISR bit 2 = 1.
